mdu_pipe: RTL and testbench
===========================

// Module: mdu_pipe
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU.
//  Takes operands from the forwarded E-stage values V1/V2 and writes results into HI/LO after a configurable latency.
//  Drives busy to the stall controller: any D-stage MDU-class instruction stalls while busy or start is high.
//  HI/LO are architectural state; mfhi/mflo read them combinationally in E.
// PARAMETERS
//  WIDTH       32  operand width; HI/LO are each WIDTH bits
//  MUL_CYCLES  5   busy cycles for mult/multu (and madd/msub when enabled); >=1
//  DIV_CYCLES  10  busy cycles for div/divu; >=1
// PORTS
//  clk    in   1      system clock, rising edge
//  reset  in   1      synchronous, active-high
//  start  in   1      E-stage MDU instruction valid this cycle
//  op     in   4      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MADDU,8 MSUB,9 MSUBU
//  a      in   WIDTH  rs operand (forwarded)
//  b      in   WIDTH  rt operand (forwarded)
//  busy   out  1      operation in flight
//  done   out  1      one-cycle pulse on the cycle HI/LO take a new multi-cycle result
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (sync): hi=0, lo=0, busy=0, done=0, counter=0, pending=0. Reset mid-operation aborts; no commit.
//  - States: IDLE, RUN. IDLE+start with multi-cycle op -> RUN, counter loaded with MUL_CYCLES or DIV_CYCLES.
//  - Result computed at accept from a/b and held in pending HI/LO regs; a/b may change afterwards.
//  - RUN: counter decrements each cycle; busy=1 for exactly N cycles starting the cycle after start.
//  - Commit: on the edge ending the last busy cycle, hi/lo <= pending, done=1 for the following cycle, -> IDLE.
//  - start while busy=1 is ignored (stall controller guarantees it does not occur; bench checks no effect).
//  - MTHI/MTLO: accepted only in IDLE; single-cycle write of a to hi/lo on next edge; busy stays 0, no done.
//  - Back-to-back: start in the cycle done=1 is accepted (state is IDLE).
//  - MULT: {hi,lo} = signed a*b, full 2*WIDTH product. MULTU: unsigned.
//  - DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend. DIVU: unsigned.
//  - Divide by zero: busy/done behave normally, hi/lo left unchanged at commit.
//  - Signed DIV of most-negative by -1: lo = most-negative, hi = 0 (wraps, no trap).
//  - Unknown op code with start=1: treated as no-op, stays IDLE.
// CONFIGURATION
//  MDU_MADD_EN defined: ops 6-9 accumulate: {hi,lo} <= {hi,lo} +/- product (signed 6,8; unsigned 7,9),
//   mod 2^(2*WIDTH); accumulator sampled at commit, latency MUL_CYCLES.
//  MDU_MADD_EN undefined: ops 6-9 are unknown ops (no-op); accumulate logic absent.
// TESTING
//  - reset held 2 cycles then released -> hi=0, lo=0, busy=0, done=0.
//  - MULT a=-3 (32'hFFFFFFFD), b=7 -> busy high 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done 1 pulse.
//  - DIV a=-7, b=2 -> busy 10 cycles, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; then DIVU a=7,b=0 -> hi/lo unchanged.
//  - MULTU a=32'hFFFFFFFF, b=2 issued, start+MTHI pulsed at cycle 2 of busy -> ignored; result hi=1, lo=32'hFFFFFFFE.
//  - MTLO a=32'h1234 from IDLE -> lo=32'h1234 next cycle, busy never asserts; reset at cycle 3 of a DIV -> hi=lo=0, busy=0.
//  - (MDU_MADD_EN) hi=0, lo=5, MADDU a=3, b=4 -> after 5 busy cycles lo=17, hi=0; MSUB a=1,b=20 -> {hi,lo}=-3.

Source files
------------

// File: rtl/mdu_pipe.sv
// mdu_pipe: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Sits in the E stage. It computes the result when the operation is accepted and
// holds it in pending registers. It then commits to HI/LO after MUL_CYCLES or
// DIV_CYCLES busy cycles.
// Optional feature: define MDU_MADD_EN to enable the multiply-accumulate ops
// (MADD/MADDU/MSUB/MSUBU). Without it, op codes 6-9 decode as no-ops.
module mdu_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic [PW-1:0]    r_pend;
  logic             r_pend_wr;
`ifdef MDU_MADD_EN
  logic             r_pend_acc;
  logic             r_pend_sub;
`endif

  logic             w_idle;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_is_acc;
  logic             w_acc_sub;
  logic             w_mul_signed;
  logic             w_go_mul;
  logic             w_go_div;
  logic             w_go_mthi;
  logic             w_go_mtlo;
  logic             w_commit;

  logic [PW-1:0]    w_ext_a;
  logic [PW-1:0]    w_ext_b;
  logic [PW-1:0]    w_prod;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: leave IDLE on an accepted multi-cycle op, return on commit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go_mul || w_go_div) w_state_nxt = S_RUN;
      S_RUN:   if (w_commit)             w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: op decode, accept strobes (IDLE only) and commit strobe
  always_comb begin
    w_idle       = (r_state == S_IDLE);
    w_is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    w_is_div     = (op == OP_DIV)  || (op == OP_DIVU);
    w_is_acc     = 1'b0;
    w_acc_sub    = 1'b0;
    w_mul_signed = (op == OP_MULT);
`ifdef MDU_MADD_EN
    w_is_acc     = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    w_acc_sub    = (op == OP_MSUB) || (op == OP_MSUBU);
    w_mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
`endif
    w_go_mul     = w_idle && start && (w_is_mul || w_is_acc);
    w_go_div     = w_idle && start && w_is_div;
    w_go_mthi    = w_idle && start && (op == OP_MTHI);
    w_go_mtlo    = w_idle && start && (op == OP_MTLO);
    w_commit     = (r_state == S_RUN) && (r_count == CW'(1));
  end

  // Product: sign/zero-extend to 2*WIDTH so one unsigned multiply serves both cases
  always_comb begin
    w_ext_a = {{WIDTH{w_mul_signed & a[WIDTH-1]}}, a};
    w_ext_b = {{WIDTH{w_mul_signed & b[WIDTH-1]}}, b};
    w_prod  = w_ext_a * w_ext_b;
  end

  // Divide on magnitudes; quotient truncates toward zero, remainder follows dividend
  always_comb begin
    w_neg_a = (op == OP_DIV) && a[WIDTH-1];
    w_neg_b = (op == OP_DIV) && b[WIDTH-1];
    w_mag_a = w_neg_a ? (-a) : a;
    w_mag_b = w_neg_b ? (-b) : b;
    if (w_mag_b == '0) begin
      w_q_mag = '0;
      w_r_mag = '0;
    end else begin
      w_q_mag = w_mag_a / w_mag_b;
      w_r_mag = w_mag_a % w_mag_b;
    end
    w_quo = (w_neg_a ^ w_neg_b) ? (-w_q_mag) : w_q_mag;
    w_rem = w_neg_a ? (-w_r_mag) : w_r_mag;
  end

  // Busy counter: loaded at accept, counts down through the RUN cycles
  always_ff @(posedge clk) begin
    if (reset)                r_count <= '0;
    else if (w_go_mul)        r_count <= CW'(MUL_CYCLES);
    else if (w_go_div)        r_count <= CW'(DIV_CYCLES);
    else if (r_state == S_RUN) r_count <= r_count - CW'(1);
  end

  // Pending result captured at accept so operands may change while running
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend     <= '0;
      r_pend_wr  <= 1'b0;
`ifdef MDU_MADD_EN
      r_pend_acc <= 1'b0;
      r_pend_sub <= 1'b0;
`endif
    end else if (w_go_mul) begin
      r_pend     <= w_prod;
      r_pend_wr  <= 1'b1;
`ifdef MDU_MADD_EN
      r_pend_acc <= w_is_acc;
      r_pend_sub <= w_acc_sub;
`endif
    end else if (w_go_div) begin
      r_pend     <= {w_rem, w_quo};
      r_pend_wr  <= (b != '0);
`ifdef MDU_MADD_EN
      r_pend_acc <= 1'b0;
      r_pend_sub <= 1'b0;
`endif
    end
  end

  // HI/LO: multi-cycle commit, or single-cycle MTHI/MTLO write from IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (r_pend_wr) begin
`ifdef MDU_MADD_EN
        if (r_pend_acc && r_pend_sub)  {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
        else if (r_pend_acc)           {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
        else                           {r_hi, r_lo} <= r_pend;
`else
        {r_hi, r_lo} <= r_pend;
`endif
      end
    end else if (w_go_mthi) begin
      r_hi <= a;
    end else if (w_go_mtlo) begin
      r_lo <= a;
    end
  end

  // done pulses for the single cycle after a commit edge
  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_commit;
  end

  // Silence unused-decode paths in the default build
  logic w_unused;
  assign w_unused = w_acc_sub;

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe: directed bench for mdu_pipe with a scoreboard of expected {hi,lo}.
// Build with MDU_MADD_EN defined to also cover the accumulate ops.
module tb_mdu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  mdu_pipe #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; operands are scrambled afterwards.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 4'hF; a = $urandom; b = $urandom;
  endtask

  // Wait out the remaining busy cycles, then compare against the scoreboard head.
  task automatic wait_commit(input string tag, input int n_busy);
    int cnt;
    logic [63:0] exp;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (done !== 1'b0) chk({tag, "_early_done"}, 64'(done), 64'd0);
      cnt++;
      tick();
    end
    chk({tag, "_busy_len"}, 64'(cnt), 64'(n_busy));
    chk({tag, "_done"}, 64'(done), 64'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_hilo"}, {hi, lo}, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
    logic signed [63:0] sx, sy;
    if (sgn) begin
      sx = 64'($signed(x));
      sy = 64'($signed(y));
      return sx * sy;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  logic [31:0] rx, ry;

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // MULT -3 * 7
    sb_q.push_back(64'hFFFFFFFF_FFFFFFEB);
    issue(4'd0, 32'hFFFFFFFD, 32'd7);
    chk("mult_busy_on", 64'(busy), 64'd1);
    chk("mult_hold", {hi, lo}, 64'd0);
    wait_commit("mult", 5);
    tick();
    chk("mult_done_pulse", 64'(done), 64'd0);

    // DIV -7 / 2, then DIVU by zero leaves HI/LO alone
    sb_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(4'd2, 32'hFFFFFFF9, 32'd2);
    wait_commit("div", 10);
    tick();
    sb_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(4'd3, 32'd7, 32'd0);
    wait_commit("divu_by0", 10);
    tick();

    // Most-negative / -1 wraps
    sb_q.push_back(64'h00000000_80000000);
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_commit("div_ovf", 10);

    // Back-to-back: MULTU issued in the done cycle; MTHI mid-busy is ignored
    chk("b2b_done", 64'(done), 64'd1);
    sb_q.push_back(64'h00000001_FFFFFFFE);
    issue(4'd1, 32'hFFFFFFFF, 32'd2);
    chk("b2b_accept", 64'(busy), 64'd1);
    tick();
    start = 1'b1; op = 4'd4; a = 32'hDEADBEEF;
    tick();
    start = 1'b0; op = 4'hF;
    wait_commit("multu_ign", 3);
    tick();

    // MTLO from IDLE
    start = 1'b1; op = 4'd5; a = 32'h1234;
    tick();
    start = 1'b0; op = 4'hF;
    chk("mtlo_lo",   64'(lo),   64'h1234);
    chk("mtlo_hi",   64'(hi),   64'd1);
    chk("mtlo_busy", 64'(busy), 64'd0);
    tick();
    chk("mtlo_done", 64'(done), 64'd0);

    // Unknown op code is a no-op
    start = 1'b1; op = 4'hC; a = 32'h5555;
    tick();
    start = 1'b0; op = 4'hF;
    chk("unk_busy", 64'(busy), 64'd0);
    chk("unk_hilo", {hi, lo}, 64'h00000001_00001234);

`ifdef MDU_MADD_EN
    // hi=0, lo=5; MADDU 3*4 -> 17; MSUB 1*20 -> -3
    start = 1'b1; op = 4'd4; a = 32'd0; tick();
    op = 4'd5; a = 32'd5; tick();
    start = 1'b0; op = 4'hF;
    sb_q.push_back(64'd17);
    issue(4'd7, 32'd3, 32'd4);
    wait_commit("maddu", 5);
    tick();
    sb_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(4'd8, 32'd1, 32'd20);
    wait_commit("msub", 5);
    tick();
`else
    // Accumulate op codes decode as no-ops without the feature
    start = 1'b1; op = 4'd6; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; op = 4'hF;
    chk("madd_off_busy", 64'(busy), 64'd0);
    tick();
    chk("madd_off_hilo", {hi, lo}, 64'h00000001_00001234);
`endif

    // Random MULT / MULTU / DIVU against the bench model
    for (int i = 0; i < 3; i++) begin
      rx = $urandom; ry = $urandom;
      sb_q.push_back(mul_model(rx, ry, 1'b1));
      issue(4'd0, rx, ry);
      wait_commit("rnd_mult", 5);
      tick();
      sb_q.push_back(mul_model(rx, ry, 1'b0));
      issue(4'd1, rx, ry);
      wait_commit("rnd_multu", 5);
      tick();
      ry = ry >> (i * 8 + 4);
      if (ry == 0) ry = 32'd3;
      sb_q.push_back({rx % ry, rx / ry});
      issue(4'd3, rx, ry);
      wait_commit("rnd_divu", 10);
      tick();
    end

    // Reset at busy cycle 3 of a DIV aborts without commit
    sb_q.push_back(64'h0);
    issue(4'd2, 32'd100, 32'd7);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(sb_q.pop_back());
    chk("abort_hi",   64'(hi),   64'd0);
    chk("abort_lo",   64'(lo),   64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) chk("abort_quiet", {62'd0, busy, done}, 64'd0);
    end
    chk("abort_final", {hi, lo}, 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
